// File: rtl/axis_packet_rr_arbiter_if.sv
// Flattened AXI-Stream bundle for the packet arbiter: NUM requester slaves and one master channel.
// The master modport is the arbiter side; the slave modport is the sources/sink side.
interface axis_packet_rr_arbiter_if #(
  parameter int NUM   = 4,
  parameter int DSIZE = 8,
  parameter int KSIZE = DSIZE / 8,
  parameter int USIZE = 1
);
  logic [NUM-1:0]       s_tvalid;
  logic [NUM-1:0]       s_tready;
  logic [NUM*DSIZE-1:0] s_tdata;
  logic [NUM*KSIZE-1:0] s_tkeep;
  logic [NUM*USIZE-1:0] s_tuser;
  logic [NUM-1:0]       s_tlast;
  logic                 m_tvalid;
  logic                 m_tready;
  logic [DSIZE-1:0]     m_tdata;
  logic [KSIZE-1:0]     m_tkeep;
  logic [USIZE-1:0]     m_tuser;
  logic                 m_tlast;

  modport master (
    input  s_tvalid, s_tdata, s_tkeep, s_tuser, s_tlast, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast
  );

  modport slave (
    output s_tvalid, s_tdata, s_tkeep, s_tuser, s_tlast, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast
  );
endinterface

// File: rtl/axis_packet_rr_arbiter.sv
// Round-robin AXI-Stream arbiter granting whole packets; the grant is released after the tlast beat.
// One IDLE cycle separates packets; BUSY is a zero-latency pass-through of the granted requester.
module axis_packet_rr_arbiter #(
  parameter int NUM   = 4,
  parameter int DSIZE = 8,
  parameter int KSIZE = DSIZE / 8,
  parameter int USIZE = 1,
  localparam int IW   = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic                      clock,
  input  logic                      rst,
  axis_packet_rr_arbiter_if.master  bus,
  output logic [IW-1:0]             grant_id,
  output logic                      busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic [15:0]     pkt_cnt_q, pkt_cnt_d;
  logic            sel_found;
  logic [IW-1:0]   sel_idx;

  // Rotating priority: first set request above last_q, then wrap to 0..last_q.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (!sel_found && (i > 32'(last_q)) && bus.s_tvalid[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
    for (int unsigned i = 0; i < NUM; i++) begin
      if (!sel_found && (i <= 32'(last_q)) && bus.s_tvalid[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    bus.m_tvalid = 1'b0;
    bus.m_tdata  = '0;
    bus.m_tkeep  = '0;
    bus.m_tuser  = '0;
    bus.m_tlast  = 1'b0;
    bus.s_tready = '0;
    if (state_q == BUSY) begin
      for (int unsigned i = 0; i < NUM; i++) begin
        if (grant_q == IW'(i)) begin
          bus.m_tvalid    = bus.s_tvalid[i];
          bus.m_tdata     = bus.s_tdata[i*DSIZE +: DSIZE];
          bus.m_tkeep     = bus.s_tkeep[i*KSIZE +: KSIZE];
          bus.m_tuser     = bus.s_tuser[i*USIZE +: USIZE];
          bus.m_tlast     = bus.s_tlast[i];
          bus.s_tready[i] = bus.m_tready;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    pkt_cnt_d = pkt_cnt_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = BUSY;
          grant_d = sel_idx;
          last_d  = sel_idx;
        end
      end
      BUSY: begin
        if (bus.m_tvalid && bus.m_tready && bus.m_tlast) begin
          state_d   = IDLE;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= IW'(NUM - 1);
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == BUSY);

endmodule

// File: tb/tb_axis_packet_rr_arbiter.sv
// Directed self-checking bench for axis_packet_rr_arbiter (NUM=4, DSIZE=8).
module tb_axis_packet_rr_arbiter;
  localparam int NUM   = 4;
  localparam int DSIZE = 8;
  localparam int KSIZE = 1;
  localparam int USIZE = 1;

  logic       clock = 1'b0;
  logic       rst;
  logic [1:0] grant_id;
  logic       busy;
  int         checks = 0;
  int         errors = 0;

  axis_packet_rr_arbiter_if #(.NUM(NUM), .DSIZE(DSIZE), .KSIZE(KSIZE), .USIZE(USIZE)) bus ();

  axis_packet_rr_arbiter #(.NUM(NUM), .DSIZE(DSIZE), .KSIZE(KSIZE), .USIZE(USIZE)) dut (
    .clock    (clock),
    .rst      (rst),
    .bus      (bus.master),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task tick;
    @(posedge clock);
    #1;
  endtask

  task clear_inputs;
    bus.s_tvalid = '0;
    bus.s_tdata  = '0;
    bus.s_tkeep  = '0;
    bus.s_tuser  = '0;
    bus.s_tlast  = '0;
    bus.m_tready = 1'b0;
  endtask

  task set_src(input int i, input logic [7:0] d, input logic last);
    bus.s_tdata[i*DSIZE +: DSIZE] = d;
    bus.s_tkeep[i]                = 1'b1;
    bus.s_tuser[i]                = d[0];
    bus.s_tlast[i]                = last;
  endtask

  task do_reset;
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task test_reset;
    rst = 1'b1;
    bus.s_tvalid = 'x;
    bus.s_tdata  = 'x;
    bus.m_tready = 1'bx;
    #2;
    clear_inputs();
    tick();
    tick();
    checks++; if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b expected 0", bus.m_tvalid); end
    checks++; if (bus.s_tready !== 4'b0000) begin errors++; $display("FAIL reset_s_tready: got %b expected 0000", bus.s_tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    checks++; if (bus.m_tdata !== 8'h00) begin errors++; $display("FAIL reset_m_tdata: got %h expected 00", bus.m_tdata); end
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req_busy: got %b expected 0", busy); end
  endtask

  task test_single_request;
    do_reset();
    set_src(0, 8'h11, 1'b1);
    set_src(1, 8'h22, 1'b1);
    set_src(3, 8'h44, 1'b1);
    set_src(2, 8'hA0, 1'b0);
    bus.s_tvalid = 4'b0100;
    bus.m_tready = 1'b1;
    #1;
    checks++; if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL single_latency_m_tvalid: got %b expected 0", bus.m_tvalid); end
    checks++; if (bus.s_tready !== 4'b0000) begin errors++; $display("FAIL single_idle_s_tready: got %b expected 0000", bus.s_tready); end
    tick();
    checks++; if (bus.m_tvalid !== 1'b1) begin errors++; $display("FAIL single_m_tvalid: got %b expected 1", bus.m_tvalid); end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_id: got %0d expected 2", grant_id); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    checks++; if (bus.m_tdata !== 8'hA0) begin errors++; $display("FAIL single_beat0_data: got %h expected a0", bus.m_tdata); end
    checks++; if (bus.s_tready !== 4'b0100) begin errors++; $display("FAIL single_s_tready: got %b expected 0100", bus.s_tready); end
    checks++; if (bus.m_tkeep !== 1'b1) begin errors++; $display("FAIL single_m_tkeep: got %b expected 1", bus.m_tkeep); end
    tick();
    set_src(2, 8'hA1, 1'b0);
    #1;
    checks++; if (bus.m_tdata !== 8'hA1 || bus.m_tuser !== 1'b1) begin errors++; $display("FAIL single_beat1: got data %h user %b expected a1 1", bus.m_tdata, bus.m_tuser); end
    tick();
    set_src(2, 8'hA2, 1'b1);
    #1;
    checks++; if (bus.m_tdata !== 8'hA2 || bus.m_tlast !== 1'b1) begin errors++; $display("FAIL single_beat2: got data %h last %b expected a2 1", bus.m_tdata, bus.m_tlast); end
    tick();
    bus.s_tvalid = 4'b0000;
    #1;
    checks++; if (busy !== 1'b0 || bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL single_release: got busy %b m_tvalid %b expected 0 0", busy, bus.m_tvalid); end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_hold: got %0d expected 2", grant_id); end
    checks++; if (bus.m_tdata !== 8'h00) begin errors++; $display("FAIL single_idle_data: got %h expected 00", bus.m_tdata); end
    clear_inputs();
  endtask

  task test_all_request;
    int beat [NUM];
    logic [NUM-1:0] hs;
    int phase, g;
    do_reset();
    for (int i = 0; i < NUM; i++) beat[i] = 0;
    bus.m_tready = 1'b1;
    bus.s_tvalid = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      for (int i = 0; i < NUM; i++) set_src(i, 8'((i << 4) | beat[i]), beat[i] == 1);
      #1;
      phase = c % 3;
      g = (c / 3) % NUM;
      if (phase == 0) begin
        checks++; if (busy !== 1'b0 || bus.m_tvalid !== 1'b0 || bus.s_tready !== 4'b0000) begin
          errors++; $display("FAIL all_idle_bubble c=%0d: got busy %b m_tvalid %b s_tready %b expected 0 0 0000", c, busy, bus.m_tvalid, bus.s_tready); end
      end else begin
        checks++; if (grant_id !== 2'(g) || busy !== 1'b1) begin
          errors++; $display("FAIL all_grant_order c=%0d: got grant %0d busy %b expected %0d 1", c, grant_id, busy, g); end
        checks++; if (bus.m_tdata !== 8'((g << 4) | (phase - 1)) || bus.m_tlast !== (phase == 2)) begin
          errors++; $display("FAIL all_data c=%0d: got %h last %b expected %h %b", c, bus.m_tdata, bus.m_tlast, 8'((g << 4) | (phase - 1)), phase == 2); end
        checks++; if (bus.s_tready !== 4'(1 << g)) begin
          errors++; $display("FAIL all_s_tready c=%0d: got %b expected %b", c, bus.s_tready, 4'(1 << g)); end
      end
      hs = bus.s_tvalid & bus.s_tready;
      tick();
      for (int i = 0; i < NUM; i++) if (hs[i]) beat[i] = (beat[i] + 1) % 2;
    end
    clear_inputs();
  endtask

  task test_backpressure;
    logic [5:0] trdy;
    logic [7:0] rx [$];
    logic hs;
    int beat, b;
    trdy = 6'b111001;
    beat = 0;
    b = 0;
    rx.delete();
    do_reset();
    for (int i = 0; i < NUM; i++) if (i != 1) set_src(i, 8'hEE, 1'b1);
    set_src(1, 8'hB0, 1'b0);
    bus.s_tvalid = 4'b0010;
    bus.m_tready = 1'b1;
    tick();
    bus.s_tvalid = 4'b1111;
    for (int cyc = 0; cyc < 12 && beat < 4; cyc++) begin
      bus.m_tready = (b < 6) ? trdy[b] : 1'b1;
      set_src(1, 8'hB0 + 8'(beat), beat == 3);
      #1;
      checks++; if (bus.s_tready !== {2'b00, bus.m_tready, 1'b0}) begin
        errors++; $display("FAIL bp_s_tready cyc=%0d: got %b expected %b", cyc, bus.s_tready, {2'b00, bus.m_tready, 1'b0}); end
      checks++; if (grant_id !== 2'd1 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_grant cyc=%0d: got grant %0d busy %b expected 1 1", cyc, grant_id, busy); end
      if (bus.m_tvalid && bus.m_tready) rx.push_back(bus.m_tdata);
      hs = bus.s_tvalid[1] & bus.s_tready[1];
      tick();
      if (hs) beat++;
      b++;
    end
    bus.s_tvalid[1] = 1'b0;
    checks++; if (beat != 4) begin errors++; $display("FAIL bp_timeout: got %0d beats accepted expected 4", beat); end
    checks++; if (rx.size() != 4) begin errors++; $display("FAIL bp_beat_count: got %0d expected 4", rx.size()); end
    for (int k = 0; k < 4 && k < rx.size(); k++) begin
      checks++; if (rx[k] !== 8'hB0 + 8'(k)) begin errors++; $display("FAIL bp_beat_data k=%0d: got %h expected %h", k, rx[k], 8'hB0 + 8'(k)); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release: got busy %b expected 0", busy); end
    checks++; if (b != 6) begin errors++; $display("FAIL bp_cycles: got %0d busy cycles expected 6", b); end
    clear_inputs();
  endtask

  task test_single_beat;
    int seq [6];
    seq = '{3, 0, 3, 0, 3, 0};
    do_reset();
    bus.m_tready = 1'b1;
    set_src(3, 8'h3C, 1'b1);
    set_src(0, 8'h0C, 1'b1);
    bus.s_tvalid = 4'b1000;
    for (int p = 0; p < 6; p++) begin
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sb_idle p=%0d: got busy %b expected 0", p, busy); end
      tick();
      if (p == 0) bus.s_tvalid = 4'b1001;
      #1;
      checks++; if (grant_id !== 2'(seq[p]) || busy !== 1'b1 || bus.m_tlast !== 1'b1) begin
        errors++; $display("FAIL sb_grant p=%0d: got grant %0d busy %b last %b expected %0d 1 1", p, grant_id, busy, bus.m_tlast, seq[p]); end
      checks++; if (bus.m_tdata !== ((seq[p] == 3) ? 8'h3C : 8'h0C)) begin
        errors++; $display("FAIL sb_data p=%0d: got %h expected %h", p, bus.m_tdata, (seq[p] == 3) ? 8'h3C : 8'h0C); end
      tick();
    end
    clear_inputs();
  endtask

  task test_reset_mid_packet;
    do_reset();
    bus.m_tready = 1'b1;
    set_src(2, 8'hC0, 1'b0);
    bus.s_tvalid = 4'b0100;
    tick();
    checks++; if (grant_id !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL rm_grant: got grant %0d busy %b expected 2 1", grant_id, busy); end
    tick();
    set_src(2, 8'hC1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.m_tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_abort: got m_tvalid %b busy %b expected 0 0", bus.m_tvalid, busy); end
    checks++; if (bus.s_tready !== 4'b0000 || bus.m_tlast !== 1'b0) begin errors++; $display("FAIL rm_outputs: got s_tready %b last %b expected 0000 0", bus.s_tready, bus.m_tlast); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rm_grant_reset: got %0d expected 0", grant_id); end
    set_src(0, 8'h0A, 1'b0);
    bus.s_tvalid = 4'b0101;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_post_idle: got busy %b expected 0", busy); end
    tick();
    checks++; if (grant_id !== 2'd0 || busy !== 1'b1 || bus.m_tdata !== 8'h0A) begin
      errors++; $display("FAIL rm_first_grant: got grant %0d busy %b data %h expected 0 1 0a", grant_id, busy, bus.m_tdata); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_all_request();
    test_backpressure();
    test_single_beat();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
